bus_master_cycle: RTL and testbench

//  Bus initiator for the 6502-style target bus. Turns single-beat requests from internal

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_master_cycle_phase_timer.sv | 27 ++
 rtl/bus_master_cycle.sv | 141 ++++++++++++++
 tb/tb_bus_master_cycle.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 6502-style bus initiator: bus widths, RWB encoding and FSM states.
package bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WAIT_W = 8;

    localparam logic RWB_READ  = 1'b1;
    localparam logic RWB_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bus_master_cycle_phase_timer.sv
// Half-phase down-counter: load restarts a HALF_CLKS-long phase, tc_c flags its last clk.
module phase_timer #(
    parameter int unsigned HALF_CLKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tc_c
);

    localparam int unsigned CNT_W = (HALF_CLKS > 1) ? $clog2(HALF_CLKS) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(HALF_CLKS - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tc_c = (cnt == '0);

endmodule

// File: rtl/bus_master_cycle.sv
// Bus initiator: turns single-beat requests into PHI1/PHI2 bus cycles with RDY stretching and timeout.
module bus_master_cycle
    import bus_pkg::*;
#(
    parameter int unsigned HALF_CLKS = 4,
    parameter int unsigned MAX_WAIT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PHI2,
    output logic [ADDR_W-1:0] A,
    output logic              RWB,
    output logic [DATA_W-1:0] D_out,
    output logic              D_oe,
    input  logic [DATA_W-1:0] D_in,
    input  logic              RDY
);

    localparam logic [WAIT_W-1:0] MAX_W    = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

    state_t              state, state_nxt;
    logic                we_q, we_nxt;
    logic [DATA_W-1:0]   wdata_q, wdata_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                req_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_W-1:0]   rsp_rdata_nxt, dout_nxt;
    logic [ADDR_W-1:0]   a_nxt;
    logic                rwb_nxt, phi2_nxt, doe_nxt;
    logic                tc_c, timer_load_c;

    // Timer free-loads outside the bus phases so PH1 always starts with a full count
    assign timer_load_c = (state == PH1 || state == PH2) ? tc_c : 1'b1;

    phase_timer #(.HALF_CLKS(HALF_CLKS)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load_c),
        .tc_c  (tc_c)
    );

    always_comb begin
        state_nxt     = state;
        we_nxt        = we_q;
        wdata_nxt     = wdata_q;
        wait_nxt      = wait_cnt;
        req_ready_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        dout_nxt      = D_out;
        a_nxt         = A;
        rwb_nxt       = RWB;
        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    state_nxt     = PH1;
                    req_ready_nxt = 1'b0;
                    a_nxt         = req_addr;
                    rwb_nxt       = req_we ? RWB_WRITE : RWB_READ;
                    we_nxt        = req_we;
                    wdata_nxt     = req_wdata;
                    wait_nxt      = '0;
                end
            end
            PH1: begin
                if (we_q) dout_nxt = wdata_q;
                if (tc_c) state_nxt = PH2;
            end
            PH2: begin
                // RDY and read data only matter on the closing clk of PHI2 high
                if (tc_c) begin
                    if (RDY) begin
                        state_nxt     = DONE;
                        rsp_err_nxt   = 1'b0;
                        rsp_rdata_nxt = we_q ? '0 : D_in;
                    end else begin
                        wait_nxt = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + WAIT_W'(1);
                        if (MAX_WAIT != 0 && wait_nxt >= MAX_W) begin
                            state_nxt     = DONE;
                            rsp_err_nxt   = 1'b1;
                            rsp_rdata_nxt = we_q ? '0 : D_in;
                        end else begin
                            state_nxt = PH1;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt     = IDLE;
                rwb_nxt       = RWB_READ;
                req_ready_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        phi2_nxt      = (state_nxt == PH2);
        doe_nxt       = (state_nxt == PH2) && we_q;
        rsp_valid_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PHI2      <= 1'b0;
            A         <= '0;
            RWB       <= RWB_READ;
            D_out     <= '0;
            D_oe      <= 1'b0;
        end else begin
            state     <= state_nxt;
            we_q      <= we_nxt;
            wdata_q   <= wdata_nxt;
            wait_cnt  <= wait_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            PHI2      <= phi2_nxt;
            A         <= a_nxt;
            RWB       <= rwb_nxt;
            D_out     <= dout_nxt;
            D_oe      <= doe_nxt;
        end
    end

endmodule

// File: tb/tb_bus_master_cycle.sv
// Directed self-checking bench for bus_master_cycle (HALF_CLKS=2; MAX_WAIT=3 and MAX_WAIT=0 instances).
module tb_bus_master_cycle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_valid0 = 1'b0;
    logic [15:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [7:0]  req_wdata = '0;
    logic [7:0]  D_in = '0;
    logic        RDY = 1'b1, RDY0 = 1'b1;

    logic        req_ready, rsp_valid, rsp_err, PHI2, RWB, D_oe;
    logic [7:0]  rsp_rdata, D_out;
    logic [15:0] A;
    logic        req_ready0, rsp_valid0, rsp_err0, phi2_0, rwb0, doe0;
    logic [7:0]  rsp_rdata0, dout0;
    logic [15:0] a0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] phi_h, doe_h, rsp_h, rwb_h;
    int          a_bad, dout_bad, cont_bad;
    logic [7:0]  rdata_c;
    logic        err_c;

    bus_master_cycle #(.HALF_CLKS(2), .MAX_WAIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PHI2(PHI2), .A(A), .RWB(RWB), .D_out(D_out), .D_oe(D_oe), .D_in(D_in), .RDY(RDY)
    );

    bus_master_cycle #(.HALF_CLKS(2), .MAX_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .PHI2(phi2_0), .A(a0), .RWB(rwb0), .D_out(dout0), .D_oe(doe0), .D_in(D_in), .RDY(RDY0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request (caller sits at a negedge) and record outputs for offsets 0..ncyc from handshake
    task automatic do_txn(input logic [15:0] addr, input logic we, input logic [7:0] wd,
                          input logic [31:0] rdy_pat, input logic [7:0] din_base,
                          input logic din_inc, input int ncyc);
        int n = 0;
        req_addr = addr; req_we = we; req_wdata = wd; req_valid = 1'b1; RDY = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("handshake_timeout", 32'(req_ready), 32'd1);
        phi_h = '0; doe_h = '0; rsp_h = '0; rwb_h = '0;
        a_bad = 0; dout_bad = 0; cont_bad = 0; rdata_c = 8'hEE; err_c = 1'bx;
        for (int k = 0; k <= ncyc; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0; req_addr = 16'hFFFF; req_we = ~we; req_wdata = ~wd;
            end
            RDY  = rdy_pat[k];
            D_in = din_base + (din_inc ? 8'(k) : 8'h00);
            phi_h[k] = PHI2; doe_h[k] = D_oe; rsp_h[k] = rsp_valid; rwb_h[k] = RWB;
            if (k >= 1 && A != addr) a_bad++;
            if (D_oe && D_out != wd) dout_bad++;
            if (D_oe && (!PHI2 || RWB)) cont_bad++;
            if (rsp_valid) begin
                rdata_c = rsp_rdata;
                err_c   = rsp_err;
            end
        end
    endtask

    initial begin
        int n, pulses, rsps, accepts, rises, ready_bad;
        logic prev;
        logic [15:0] q[$];
        logic [15:0] exp_a;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_phi2", 32'(PHI2), 32'd0);
        check("rst_rwb", 32'(RWB), 32'd1);
        check("rst_doe", 32'(D_oe), 32'd0);
        check("rst_a", 32'(A), 32'd0);
        check("rst_dout", 32'(D_out), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_req_ready", 32'(req_ready), 32'd1);

        // 1: plain read
        do_txn(16'hC000, 1'b0, 8'h00, 32'hFFFF_FFFF, 8'h5A, 1'b0, 7);
        check("rd_phi2", phi_h, 32'h18);
        check("rd_rsp", rsp_h, 32'h20);
        check("rd_doe", doe_h, 32'h0);
        check("rd_rwb", rwb_h, 32'hFF);
        check("rd_a", 32'(a_bad), 32'd0);
        check("rd_data", 32'(rdata_c), 32'h5A);
        check("rd_err", 32'(err_c), 32'd0);

        // 2: write
        do_txn(16'h0200, 1'b1, 8'hA5, 32'hFFFF_FFFF, 8'h00, 1'b0, 7);
        check("wr_phi2", phi_h, 32'h18);
        check("wr_doe", doe_h, 32'h18);
        check("wr_rwb", rwb_h, 32'hC1);
        check("wr_rsp", rsp_h, 32'h20);
        check("wr_dout", 32'(dout_bad), 32'd0);
        check("wr_contention", 32'(cont_bad), 32'd0);
        check("wr_rdata", 32'(rdata_c), 32'h00);
        check("wr_a", 32'(a_bad), 32'd0);

        // 3: two stretches; RDY high everywhere except the first two PH2 sample clks
        do_txn(16'h4321, 1'b0, 8'h00, 32'hFFFF_FEEF, 8'h10, 1'b1, 14);
        check("st_phi2", phi_h, 32'h1998);
        check("st_rsp", rsp_h, 32'h2000);
        check("st_a", 32'(a_bad), 32'd0);
        check("st_data", 32'(rdata_c), 32'h1C);
        check("st_err", 32'(err_c), 32'd0);

        // 4: RDY stuck low, timeout after three samples
        do_txn(16'h5555, 1'b0, 8'h00, 32'h0, 8'h77, 1'b0, 14);
        check("to_phi2", phi_h, 32'h1998);
        check("to_rsp", rsp_h, 32'h2000);
        check("to_err", 32'(err_c), 32'd1);

        // 4b: MAX_WAIT=0 waits forever, then completes once RDY rises
        RDY = 1'b1;
        req_addr = 16'h3000; req_we = 1'b0; RDY0 = 1'b0; req_valid0 = 1'b1;
        check("inf_ready", 32'(req_ready0), 32'd1);
        @(negedge clk);
        req_valid0 = 1'b0;
        pulses = 0; rsps = 0; prev = phi2_0;
        for (int c = 0; c < 210; c++) begin
            @(negedge clk);
            if (phi2_0 && !prev) pulses++;
            if (rsp_valid0) rsps++;
            prev = phi2_0;
        end
        check("inf_pulses", 32'(pulses >= 50), 32'd1);
        check("inf_no_rsp", 32'(rsps), 32'd0);
        RDY0 = 1'b1;
        n = 0;
        while (!rsp_valid0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("inf_resume", 32'(rsp_valid0), 32'd1);
        check("inf_err", 32'(rsp_err0), 32'd0);
        @(negedge clk);

        // 5: reset in the middle of a write's PH2
        req_addr = 16'h0300; req_we = 1'b1; req_wdata = 8'h3C; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
        end
        check("mr_pre_phi2", {30'd0, PHI2, D_oe}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("mr_phi2", 32'(PHI2), 32'd0);
        check("mr_doe", 32'(D_oe), 32'd0);
        check("mr_rwb", 32'(RWB), 32'd1);
        check("mr_rsp", 32'(rsp_valid), 32'd0);
        check("mr_ready", 32'(req_ready), 32'd0);
        rsps = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) rsps++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (rsp_valid) rsps++;
        check("mr_no_rsp", 32'(rsps), 32'd0);
        check("mr_rel_ready", 32'(req_ready), 32'd1);
        do_txn(16'h8001, 1'b0, 8'h00, 32'hFFFF_FFFF, 8'hC3, 1'b0, 7);
        check("mr_rd_rsp", rsp_h, 32'h20);
        check("mr_rd_data", 32'(rdata_c), 32'hC3);

        // 6: req_valid held high with a new address every clk
        RDY = 1'b1;
        req_we = 1'b0; req_valid = 1'b1;
        accepts = 0; rises = 0; rsps = 0; ready_bad = 0; prev = PHI2;
        for (int c = 0; c < 52; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 40) req_valid = 1'b0;
            req_addr = 16'h1000 + 16'(c);
            if (req_valid && req_ready) begin
                q.push_back(req_addr);
                accepts++;
            end
            if (PHI2 && !prev) begin
                rises++;
                if (q.size() == 0) begin
                    check("b2b_underflow", 32'(q.size()), 32'd1);
                end else begin
                    exp_a = q.pop_front();
                    check("b2b_addr", 32'(A), 32'(exp_a));
                end
            end
            prev = PHI2;
            if (rsp_valid) rsps++;
            if (req_ready && (PHI2 || rsp_valid)) ready_bad++;
        end
        check("b2b_accepts", 32'(accepts), 32'd7);
        check("b2b_rises", 32'(rises), 32'd7);
        check("b2b_rsps", 32'(rsps), 32'd7);
        check("b2b_ready_busy", 32'(ready_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
